// File: rtl/sha256_multiblock_core.sv
`default_nettype none
// ============================================================================
// Module   : sha256_multiblock_core
// Purpose  : Iterative SHA-256 compression core for one 512-bit block at a
//            time. Hash state is chained across blocks so that long messages
//            can be hashed. The message schedule is produced on the fly from a
//            sliding 16-word window.
// Ports    : clk          - clock, rising edge
//            reset        - asynchronous reset, active low
//            init         - start first block of a message (loads IV)
//            next         - start a following block (chains stored H0..H7)
//            block_in     - padded block, word 0 in bits [511:480]
//            ready        - core idle, init/next accepted
//            digest       - H0..H7, H0 in the MSBs; held until next FINAL
//            digest_valid - one-cycle pulse when a block completes
//            w_dbg        - current schedule word W[t] (0 unless DEBUG_W_EN)
//            mode_224     - (SHA256_SHA224_MODE_EN only) SHA-224 select,
//                           sampled on init
// Params   : ROUNDS_PER_CYCLE - rounds per clock, 1, 2 or 4
//            DEBUG_W_EN       - drive w_dbg with W[t] when 1
// Macro    : SHA256_SHA224_MODE_EN adds the mode_224 port and SHA-224 support
// Revision : 1.0 - initial release
// ============================================================================
module sha256_multiblock_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int DEBUG_W_EN       = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         next,
  input  logic [511:0] block_in,
  output logic         ready,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic [31:0]  w_dbg
`ifdef SHA256_SHA224_MODE_EN
  ,
  input  logic         mode_224
`endif
);

  typedef logic [0:7][31:0]  st_t;   // index 0 = a / H0 (MSBs)
  typedef logic [0:15][31:0] win_t;  // index 0 = W[t]

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam st_t c_iv256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] c_k = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // --------------------------------------------------------------------------
  // Round primitives
  // --------------------------------------------------------------------------
  function automatic logic [31:0] f_rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic st_t f_round(input st_t s, input logic [31:0] w,
                                  input logic [31:0] k);
    logic [31:0] v_s0, v_s1, v_ch, v_maj, v_t1, v_t2;
    v_s1  = f_rotr(s[4], 6) ^ f_rotr(s[4], 11) ^ f_rotr(s[4], 25);
    v_ch  = (s[4] & s[5]) ^ (~s[4] & s[6]);
    v_t1  = s[7] + v_s1 + v_ch + k + w;
    v_s0  = f_rotr(s[0], 2) ^ f_rotr(s[0], 13) ^ f_rotr(s[0], 22);
    v_maj = (s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]);
    v_t2  = v_s0 + v_maj;
    return {v_t1 + v_t2, s[0], s[1], s[2], s[3] + v_t1, s[4], s[5], s[6]};
  endfunction

  // Shift the window by one word and append W[t+16]. Words computed near the
  // end of the block are never consumed, which is harmless.
  function automatic win_t f_slide(input win_t w);
    logic [31:0] v_ss0, v_ss1;
    v_ss0 = f_rotr(w[1], 7) ^ f_rotr(w[1], 18) ^ (w[1] >> 3);
    v_ss1 = f_rotr(w[14], 17) ^ f_rotr(w[14], 19) ^ (w[14] >> 10);
    return {w[1:15], v_ss1 + w[9] + v_ss0 + w[0]};
  endfunction

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_state_nx;
  logic [5:0]  r_t;
  st_t         r_wk;
  st_t         r_h;
  win_t        r_w;
  logic [255:0] r_digest;
  logic        r_digest_valid;

  logic        w_accept;
  logic        w_last;
  st_t         w_iv;
  st_t         w_st_nx;
  win_t        w_win_nx;
  st_t         w_h_sum;
  logic [31:0] w_low;

`ifdef SHA256_SHA224_MODE_EN
  localparam st_t c_iv224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };
  logic r_mode224;

  assign w_iv  = mode_224 ? c_iv224 : c_iv256;
  // SHA-224 truncates to H0..H6; the unused H7 lane reads zero.
  assign w_low = r_mode224 ? 32'd0 : w_h_sum[7];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode224 <= 1'b0;
    end else if (w_accept && init) begin
      r_mode224 <= mode_224;
    end
  end
`else
  assign w_iv  = c_iv256;
  assign w_low = w_h_sum[7];
`endif

  // ready also stays low during the digest_valid cycle so a new block can
  // never be accepted on the same edge the previous one is reported.
  assign ready        = (r_state == IDLE) && !r_digest_valid;
  assign digest       = r_digest;
  assign digest_valid = r_digest_valid;
  assign w_last       = (r_t == 6'(64 - ROUNDS_PER_CYCLE));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        if (ready && (init || next)) begin
          w_accept   = 1'b1;
          w_state_nx = ROUND;
        end
      end
      ROUND: begin
        if (w_last) begin
          w_state_nx = FINAL;
        end
      end
      FINAL: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Round datapath: ROUNDS_PER_CYCLE rounds chained combinationally
  // --------------------------------------------------------------------------
  always_comb begin
    w_st_nx  = r_wk;
    w_win_nx = r_w;
    for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
      w_st_nx  = f_round(w_st_nx, w_win_nx[0], c_k[r_t + 6'(k)]);
      w_win_nx = f_slide(w_win_nx);
    end
  end

  always_comb begin
    w_h_sum = '0;
    for (int i = 0; i < 8; i++) begin
      w_h_sum[i] = r_h[i] + r_wk[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_t            <= 6'd0;
      r_wk           <= '0;
      r_w            <= '0;
      r_h            <= c_iv256;
      r_digest       <= '0;
      r_digest_valid <= 1'b0;
    end else begin
      r_digest_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_w <= block_in;
            r_t <= 6'd0;
            if (init) begin
              r_wk <= w_iv;
              r_h  <= w_iv;
            end else begin
              r_wk <= r_h;
            end
          end
        end
        ROUND: begin
          r_wk <= w_st_nx;
          r_w  <= w_win_nx;
          r_t  <= r_t + 6'(ROUNDS_PER_CYCLE);
        end
        FINAL: begin
          r_h            <= w_h_sum;
          r_digest       <= {w_h_sum[0:6], w_low};
          r_digest_valid <= 1'b1;
        end
        default: begin
          r_t <= 6'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Debug schedule word
  // --------------------------------------------------------------------------
  generate
    if (DEBUG_W_EN != 0) begin : g_dbg_on
      assign w_dbg = (r_state == ROUND) ? r_w[0] : 32'd0;
    end else begin : g_dbg_off
      assign w_dbg = 32'd0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/sha256_multiblock_core.md
SHA256_MULTIBLOCK_CORE -- requirements
Module: sha256_multiblock_core

Interface
REQ-001 SHALL have parameter: ROUNDS_PER_CYCLE, 1, compression rounds per clock; legal values 1, 2, 4.
REQ-002 SHALL have parameter: DEBUG_W_EN, 0, when 1 drives w_dbg with the current schedule word.
REQ-003 SHALL have port: clk  input  1  single clock, rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: init  input  1  start the first block of a new message; loads the IV.
REQ-006 SHALL have port: next  input  1  start a following block; chains the current hash state.
REQ-007 SHALL have port: block_in  input  512  padded message block, word 0 in bits [511:480].
REQ-008 SHALL have port: ready  output  1  core idle; init/next accepted.
REQ-009 SHALL have port: digest  output  256  H0..H7 concatenated, H0 in the MSBs.
REQ-010 SHALL have port: digest_valid  output  1  one-cycle pulse when a block completes.
REQ-011 SHALL have port: w_dbg  output  32  current W[t]; tied to 0 when DEBUG_W_EN=0.

Function
REQ-012 SHALL implement an FSM with states IDLE, ROUND, FINAL.
REQ-013 IDLE: ready=1; when init or next is sampled high, SHALL capture block_in into a 16-word schedule window and go to ROUND.
REQ-014 On init, SHALL load the working and hash state from the SHA-256 IV (6a09e667 ... 5be0cd19).
REQ-015 On next, SHALL load the working state from the stored H0..H7 of the previous block.
REQ-016 If init and next are high together, SHALL give init priority.
REQ-017 SHALL ignore init/next while ready=0; no queuing.
REQ-018 ROUND: SHALL execute ROUNDS_PER_CYCLE rounds per cycle using a round counter t (0..63) that increments by ROUNDS_PER_CYCLE.
REQ-019 SHALL produce W[t] for t>=16 on the fly from the sliding 16-word window, sigma1(W[t-2])+W[t-7]+sigma0(W[t-15])+W[t-16]; no 64-word array.
REQ-020 SHALL perform all additions modulo 2^32 and rotations as true 32-bit rotates.
REQ-021 After the last round group, SHALL go to FINAL; FINAL SHALL add the working variables into H0..H7, pulse digest_valid, and return to IDLE.
REQ-022 Latency, from the accept edge to the digest_valid edge, SHALL be 64/ROUNDS_PER_CYCLE + 1 cycles (65 at the default).
REQ-023 ready SHALL be low from the cycle after accept until the cycle after digest_valid.
REQ-024 digest SHALL hold its value until the next FINAL; it is not cleared by a new init.
REQ-025 next issued directly after reset, with no prior init, SHALL chain from the IV.

Reset
REQ-026 Asserting reset, at any time including mid-block, SHALL asynchronously force state=IDLE, t=0, ready=1, digest_valid=0, digest=0, w_dbg=0, and H0..H7=IV.
REQ-027 After reset is released, the first accepted init/next SHALL be sampled no earlier than the next rising clk.

Configuration
REQ-028 Macro SHA256_SHA224_MODE_EN: when defined, SHALL add port mode_224 (input, 1), sampled on init.
REQ-029 With the macro defined and mode_224=1, init SHALL load the SHA-224 IV (c1059ed8 ... befa4fa4), and digest[31:0] SHALL read 0.
REQ-030 Without the macro, SHALL have no mode_224 port and SHALL run SHA-256 only.

Verification
REQ-031 Padded "abc" block (61626380, zeros, 00000018), init -> digest_valid after 65 cycles; digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-032 Empty-message block (80000000, zeros), init -> e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-033 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with init, block 2 with next -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-034 Reset asserted at round 30, then "abc" with init -> no digest_valid for the aborted block; correct "abc" digest.
REQ-035 init pulsed while busy -> ignored; digest unchanged; ready stays low until done.
REQ-036 SHA256_SHA224_MODE_EN defined, mode_224=1, "abc" -> 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000.
